// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pkg;

  // Operation select values on the mode input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits added per pipeline stage. A zero stage count is rejected at
  // elaboration by the top level; guard the division so that check is reached.
  function automatic int unsigned chunk_width(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  // The adder pipeline itself.
  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );

endinterface

// File: rtl/addsub_stage.sv
// One registered slice of the pipelined adder. The low ChunkW bits of the
// operand vectors are consumed each stage; the sum chunk is rotated in at the
// top of the A vector so that after the last stage A holds the full result.
module addsub_stage #(
  parameter int unsigned Width  = 16,
  parameter int unsigned ChunkW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             mode_i,
  input  logic             amsb_i,
  input  logic             bmsb_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic [Width-1:0] a_o,
  output logic [Width-1:0] b_o,
  output logic             mode_o,
  output logic             amsb_o,
  output logic             bmsb_o
);

  logic [ChunkW:0]  sum;
  logic [Width-1:0] a_next;
  logic [Width-1:0] b_next;

  logic             valid_q;
  logic             carry_q;
  logic [Width-1:0] a_q;
  logic [Width-1:0] b_q;
  logic             mode_q;
  logic             amsb_q;
  logic             bmsb_q;

  // Chunk add: low operand chunks plus the carry from the previous stage.
  assign sum = {1'b0, a_i[ChunkW-1:0]} + {1'b0, b_i[ChunkW-1:0]} + {{ChunkW{1'b0}}, carry_i};

  if (ChunkW == Width) begin : g_single
    assign a_next = sum[ChunkW-1:0];
    assign b_next = '0;
  end else begin : g_multi
    // Shift consumed chunks out, rotate the fresh sum chunk into the top of A.
    assign a_next = {sum[ChunkW-1:0], a_i[Width-1:ChunkW]};
    assign b_next = {{ChunkW{1'b0}}, b_i[Width-1:ChunkW]};
  end

  // Stage register: captures on enable; payload only moves with a valid operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        carry_q <= sum[ChunkW];
        a_q     <= a_next;
        b_q     <= b_next;
        mode_q  <= mode_i;
        amsb_q  <= amsb_i;
        bmsb_q  <= bmsb_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign mode_o  = mode_q;
  assign amsb_o  = amsb_q;
  assign bmsb_o  = bmsb_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshakes.
// STAGES slices each add WIDTH/STAGES bits; the last slice is the output register.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic          clk,
  input logic          rst_n,
  addsub_pipe_if.slave bus
);

  localparam int unsigned ChunkW = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("addsub_pipe: STAGES must lie in 1..WIDTH");
  end
  if (STAGES != 0 && (WIDTH % STAGES) != 0) begin : g_bad_split
    $error("addsub_pipe: WIDTH must be a multiple of STAGES");
  end

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic [STAGES:0]  valid_c;
  logic [STAGES:0]  carry_c;
  logic [STAGES:0]  mode_c;
  logic [STAGES:0]  amsb_c;
  logic [STAGES:0]  bmsb_c;
  logic [WIDTH-1:0] a_c [STAGES+1];
  logic [WIDTH-1:0] b_c [STAGES+1];

  logic [WIDTH-1:0] beff;
  logic [STAGES-1:0] en;
  logic [WIDTH-1:0] res;
  logic             unused_tail;

  // Subtraction is a + ~b + cin; the caller supplies cin=1 for a true difference.
  assign beff = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;

  assign valid_c[0] = bus.in_valid;
  assign carry_c[0] = bus.cin;
  assign a_c[0]     = bus.a;
  assign b_c[0]     = beff;
  assign mode_c[0]  = bus.mode;
  assign amsb_c[0]  = bus.a[WIDTH-1];
  assign bmsb_c[0]  = beff[WIDTH-1];

  // Ready chain, back to front: a stage may load when empty or when it moves on.
  always_comb begin : p_ready
    logic nxt;
    nxt = bus.out_ready;
    en  = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      en[k] = !valid_c[k+1] || nxt;
      nxt   = en[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .Width (WIDTH),
      .ChunkW(ChunkW)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en[k]),
      .valid_i(valid_c[k]),
      .carry_i(carry_c[k]),
      .a_i    (a_c[k]),
      .b_i    (b_c[k]),
      .mode_i (mode_c[k]),
      .amsb_i (amsb_c[k]),
      .bmsb_i (bmsb_c[k]),
      .valid_o(valid_c[k+1]),
      .carry_o(carry_c[k+1]),
      .a_o    (a_c[k+1]),
      .b_o    (b_c[k+1]),
      .mode_o (mode_c[k+1]),
      .amsb_o (amsb_c[k+1]),
      .bmsb_o (bmsb_c[k+1])
    );
  end

  assign res = a_c[STAGES];

  assign bus.in_ready  = en[0];
  assign bus.out_valid = valid_c[STAGES];
  assign bus.s         = res;
  assign bus.cout      = carry_c[STAGES];
  // Same-sign operands whose result sign differs overflowed.
  assign bus.ovf       = (amsb_c[STAGES] == bmsb_c[STAGES]) && (res[WIDTH-1] != amsb_c[STAGES]);
  // Qualified by valid so the reset state reports zero=0.
  assign bus.zero      = valid_c[STAGES] && (res == '0);

  // Fully consumed operand bits and the carried mode have no consumer past the end.
  assign unused_tail = ^{b_c[STAGES], mode_c[STAGES]};

endmodule
